// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if
//   Bundles the handshake and memory-pin signals of the data-memory port arbiter.
//   slave  : the arbiter's view (takes requests, drives grants and memory pins).
//   master : the requesters'/memory view (drives requests, samples grants).
//   Scalar port : s_req, s_we, s_addr, s_wdata, s_byte_sel -> s_gnt, s_rdata
//   Matrix port : m_start, m_we, m_base, m_stride, m_len, m_wdata
//                 -> m_wready, m_rvalid, m_rdata, m_busy, m_done
//   Memory pins : data_addr, w_data_mem, r_en_mem, w_en_mem, byte_sel,
//                 mst_or_mvtr -> memory; r_data_mem <- memory
interface dmem_port_arbiter_if #(
    parameter int LEN_W = 5
);
    logic             s_req;
    logic             s_we;
    logic [31:0]      s_addr;
    logic [31:0]      s_wdata;
    logic [1:0]       s_byte_sel;
    logic             s_gnt;
    logic [31:0]      s_rdata;

    logic             m_start;
    logic             m_we;
    logic [31:0]      m_base;
    logic [31:0]      m_stride;
    logic [LEN_W-1:0] m_len;
    logic [31:0]      m_wdata;
    logic             m_wready;
    logic             m_rvalid;
    logic [31:0]      m_rdata;
    logic             m_busy;
    logic             m_done;

    logic [31:0]      data_addr;
    logic [31:0]      w_data_mem;
    logic             r_en_mem;
    logic             w_en_mem;
    logic [1:0]       byte_sel;
    logic             mst_or_mvtr;
    logic [31:0]      r_data_mem;

    modport slave (
        input  s_req, s_we, s_addr, s_wdata, s_byte_sel,
        output s_gnt, s_rdata,
        input  m_start, m_we, m_base, m_stride, m_len, m_wdata,
        output m_wready, m_rvalid, m_rdata, m_busy, m_done,
        output data_addr, w_data_mem, r_en_mem, w_en_mem, byte_sel, mst_or_mvtr,
        input  r_data_mem
    );

    modport master (
        output s_req, s_we, s_addr, s_wdata, s_byte_sel,
        input  s_gnt, s_rdata,
        output m_start, m_we, m_base, m_stride, m_len, m_wdata,
        input  m_wready, m_rvalid, m_rdata, m_busy, m_done,
        input  data_addr, w_data_mem, r_en_mem, w_en_mem, byte_sel, mst_or_mvtr,
        output r_data_mem
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single-ported byte-addressed data memory between the scalar
//   load/store port and the matrix unit. A burst sequencer walks
//   base + k*stride for matrix bursts; each cycle a round-robin arbiter grants
//   one requester and drives the memory pins in that same cycle.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous, active-low reset
//     bus  : dmem_port_arbiter_if.slave (scalar port, matrix port, memory pins)
module dmem_port_arbiter #(
    parameter int LEN_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    dmem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_addr;
    logic [LEN_W-1:0] r_rem;
    logic             r_dir;
    logic             r_last_m;   // 1: matrix held the most recent grant
    logic             r_rvalid;
    logic [31:0]      r_rdata;

    logic             w_gnt_m;
    logic             w_gnt_s;

    // Next state and arbitration. On a conflict the requester that did not
    // hold the last grant wins.
    always_comb begin
        w_next  = r_state;
        w_gnt_m = 1'b0;
        w_gnt_s = 1'b0;
        if (r_state == BURST) begin
            w_gnt_m = !bus.s_req || !r_last_m;
        end
        w_gnt_s = bus.s_req && !w_gnt_m;
        case (r_state)
            IDLE: begin
                if (bus.m_start) begin
                    w_next = (bus.m_len != '0) ? BURST : DONE;
                end
            end
            BURST: begin
                if (w_gnt_m && (r_rem == LEN_W'(1))) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Memory pin drive for the granted requester; idle pattern otherwise.
    always_comb begin
        bus.data_addr   = '0;
        bus.w_data_mem  = '0;
        bus.r_en_mem    = 1'b0;
        bus.w_en_mem    = 1'b0;
        bus.byte_sel    = '0;
        bus.mst_or_mvtr = 1'b1;
        bus.s_gnt       = w_gnt_s;
        bus.s_rdata     = bus.r_data_mem;
        bus.m_wready    = w_gnt_m && r_dir;
        if (w_gnt_s) begin
            bus.data_addr  = bus.s_addr;
            bus.byte_sel   = bus.s_byte_sel;
            bus.w_en_mem   = bus.s_we;
            bus.r_en_mem   = !bus.s_we;
            bus.w_data_mem = bus.s_we ? bus.s_wdata : '0;
        end else if (w_gnt_m) begin
            bus.data_addr   = r_addr;
            bus.byte_sel    = 2'b10;
            bus.mst_or_mvtr = 1'b0;
            bus.w_en_mem    = r_dir;
            bus.r_en_mem    = !r_dir;
            bus.w_data_mem  = r_dir ? bus.m_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_rem    <= '0;
            r_dir    <= 1'b0;
            r_last_m <= 1'b1;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && bus.m_start) begin
                r_addr <= bus.m_base;
                r_rem  <= bus.m_len;
                r_dir  <= bus.m_we;
            end
            if (w_gnt_m) begin
                r_addr <= r_addr + bus.m_stride;
                r_rem  <= r_rem - LEN_W'(1);
            end
            if (w_gnt_m || w_gnt_s) begin
                r_last_m <= w_gnt_m;
            end
            r_rvalid <= w_gnt_m && !r_dir;
            if (w_gnt_m && !r_dir) begin
                r_rdata <= bus.r_data_mem;
            end
        end
    end

    assign bus.m_rvalid = r_rvalid;
    assign bus.m_rdata  = r_rdata;
    assign bus.m_busy   = (r_state == BURST);
    assign bus.m_done   = (r_state == DONE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
//   Scoreboard bench: each test pushes the memory accesses and burst read words
//   it expects; a negedge monitor pops and compares them as the DUT produces them.
//   A byte-addressed model memory (256 bytes, low address bits) sits on the pins.
module tb_dmem_port_arbiter;
    localparam int LEN_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.LEN_W(LEN_W)) bus ();
    dmem_port_arbiter #(.LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model memory with a backdoor for preloading; only this block writes it.
    logic [7:0]  mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_a  = '0;
    logic [31:0] bd_d  = '0;
    logic        widx_clr = 1'b0;
    logic [3:0]  widx = '0;
    logic [31:0] wwords [0:15];
    logic [7:0]  ra;

    assign ra             = bus.data_addr[7:0];
    assign bus.r_data_mem = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
    assign bus.m_wdata    = wwords[widx];

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_a]        <= bd_d[7:0];
            mem[bd_a + 8'd1] <= bd_d[15:8];
            mem[bd_a + 8'd2] <= bd_d[23:16];
            mem[bd_a + 8'd3] <= bd_d[31:24];
        end else if (bus.w_en_mem) begin
            mem[ra] <= bus.w_data_mem[7:0];
            if (!bus.mst_or_mvtr || bus.byte_sel != 2'b00) begin
                mem[ra + 8'd1] <= bus.w_data_mem[15:8];
            end
            if (!bus.mst_or_mvtr || bus.byte_sel == 2'b10) begin
                mem[ra + 8'd2] <= bus.w_data_mem[23:16];
                mem[ra + 8'd3] <= bus.w_data_mem[31:24];
            end
        end
        if (widx_clr) widx <= '0;
        else if (bus.m_wready) widx <= widx + 4'd1;
    end

    function automatic logic [31:0] rd_word(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    // Access record: {w_en, r_en, s_gnt, m_wready, mst_or_mvtr, byte_sel, addr, wdata}
    typedef logic [70:0] acc_t;
    acc_t        exp_acc [$];
    logic [31:0] exp_rd  [$];
    logic [31:0] exp_srd [$];

    function automatic acc_t m_acc(input logic we, input logic [31:0] a, input logic [31:0] wd);
        return {we, !we, 1'b0, we, 1'b0, 2'b10, a, wd};
    endfunction

    function automatic acc_t s_acc(input logic we, input logic [1:0] bs,
                                   input logic [31:0] a, input logic [31:0] wd);
        return {we, !we, 1'b1, 1'b0, 1'b1, bs, a, wd};
    endfunction

    initial begin : monitor
        logic prev_mread;
        acc_t obs;
        acc_t e;
        prev_mread = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_mread = 1'b0;
                continue;
            end
            obs = {bus.w_en_mem, bus.r_en_mem, bus.s_gnt, bus.m_wready, bus.mst_or_mvtr,
                   bus.byte_sel, bus.data_addr, bus.w_data_mem};
            if (bus.w_en_mem || bus.r_en_mem) begin
                check("acc_expected", 96'(exp_acc.size() != 0), 96'(1));
                check("rw_excl", 96'(bus.w_en_mem && bus.r_en_mem), 96'(0));
                if (exp_acc.size() != 0) begin
                    e = exp_acc.pop_front();
                    check("access", 96'(obs), 96'(e));
                end
                if (bus.s_gnt && bus.r_en_mem && exp_srd.size() != 0) begin
                    check("s_rdata", 96'(bus.s_rdata), 96'(exp_srd.pop_front()));
                end
            end else begin
                check("idle_bus", {bus.data_addr, bus.w_data_mem, bus.byte_sel, bus.mst_or_mvtr},
                      {32'h0, 32'h0, 2'b00, 1'b1});
            end
            check("rvalid", 96'(bus.m_rvalid), 96'(prev_mread));
            if (bus.m_rvalid) begin
                check("rd_expected", 96'(exp_rd.size() != 0), 96'(1));
                if (exp_rd.size() != 0) check("m_rdata", 96'(bus.m_rdata), 96'(exp_rd.pop_front()));
            end
            prev_mread = bus.r_en_mem && !bus.mst_or_mvtr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [7:0] a, input logic [31:0] d);
        bd_a  = a;
        bd_d  = d;
        bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic start_burst(input logic we, input logic [31:0] base,
                               input logic [31:0] stride, input logic [LEN_W-1:0] len);
        bus.m_we     = we;
        bus.m_base   = base;
        bus.m_stride = stride;
        bus.m_len    = len;
        bus.m_start  = 1'b1;
        tick();
        bus.m_start  = 1'b0;
    endtask

    // Cycle 1 is the first cycle after the edge that sampled m_start.
    task automatic wait_done(input string tag, input int unsigned exp_lat);
        logic seen;
        seen = 1'b0;
        for (int unsigned n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) check({tag, "_busy1"}, 96'(bus.m_busy), 96'(exp_lat > 1));
            if (bus.m_done) begin
                check({tag, "_done_lat"}, 96'(n), 96'(exp_lat));
                check({tag, "_busy_at_done"}, 96'(bus.m_busy), 96'(0));
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 96'(bus.m_done), 96'(1));
        @(negedge clk);
        check({tag, "_done_pulse"}, 96'(bus.m_done), 96'(0));
        tick();
    endtask

    initial begin : main
        bus.s_req = 1'b0; bus.s_we = 1'b0; bus.s_addr = '0; bus.s_wdata = '0;
        bus.s_byte_sel = 2'b10;
        bus.m_start = 1'b0; bus.m_we = 1'b0; bus.m_base = '0; bus.m_stride = '0; bus.m_len = '0;
        for (int unsigned i = 0; i < 16; i++) wwords[i] = '0;
        for (int unsigned i = 0; i < 256; i++) bd_write(8'(i), 32'h0);

        #1;
        check("rst_busy",   96'(bus.m_busy),   96'(0));
        check("rst_rvalid", 96'(bus.m_rvalid), 96'(0));
        check("rst_done",   96'(bus.m_done),   96'(0));
        check("rst_rdata",  96'(bus.m_rdata),  96'(0));
        tick();
        rst = 1'b1;
        tick();

        // Load burst, no scalar traffic.
        for (int unsigned k = 0; k < 4; k++) begin
            bd_write(8'(32'h10 + 4 * k), 32'hC0DE_0010 + 32'(4 * k));
            exp_acc.push_back(m_acc(1'b0, 32'h10 + 32'(4 * k), 32'h0));
            exp_rd.push_back(32'hC0DE_0010 + 32'(4 * k));
        end
        start_burst(1'b0, 32'h10, 32'd4, 5'd4);
        wait_done("load", 5);
        tick();
        check("load_left", 96'(exp_acc.size() + exp_rd.size()), 96'(0));

        // Store burst against a persistent scalar read: grants alternate, scalar first.
        bd_write(8'h80, 32'h5CA1_AB1E);
        widx_clr = 1'b1; tick(); widx_clr = 1'b0;
        wwords[0] = 32'hDEAD_0000; wwords[1] = 32'hDEAD_0008; wwords[2] = 32'hDEAD_0010;
        bus.s_we = 1'b0; bus.s_addr = 32'h80; bus.s_byte_sel = 2'b10;
        for (int unsigned k = 0; k < 3; k++) begin
            exp_acc.push_back(s_acc(1'b0, 2'b10, 32'h80, 32'h0));
            exp_srd.push_back(32'h5CA1_AB1E);
            exp_acc.push_back(m_acc(1'b1, 32'(8 * k), 32'hDEAD_0000 + 32'(8 * k)));
        end
        start_burst(1'b1, 32'h0, 32'd8, 5'd3);
        bus.s_req = 1'b1;
        fork
            begin
                repeat (6) @(posedge clk);
                #1 bus.s_req = 1'b0;
            end
        join_none
        wait_done("store", 7);
        check("store_w0", 96'(rd_word(8'h00)), 96'(32'hDEAD_0000));
        check("store_w1", 96'(rd_word(8'h08)), 96'(32'hDEAD_0008));
        check("store_w2", 96'(rd_word(8'h10)), 96'(32'hDEAD_0010));
        check("store_left", 96'(exp_acc.size() + exp_srd.size()), 96'(0));

        // Scalar byte store.
        bd_write(8'h04, 32'h1122_3344);
        exp_acc.push_back(s_acc(1'b1, 2'b00, 32'h5, 32'hAABB_CCDD));
        bus.s_we = 1'b1; bus.s_byte_sel = 2'b00; bus.s_addr = 32'h5; bus.s_wdata = 32'hAABB_CCDD;
        bus.s_req = 1'b1;
        @(negedge clk);
        check("sbyte_gnt", 96'(bus.s_gnt), 96'(1));
        tick();
        bus.s_req = 1'b0;
        check("sbyte_mem", 96'(rd_word(8'h04)), 96'(32'h1122_DD44));

        // Zero-length burst: no access, done on cycle 1.
        start_burst(1'b0, 32'h20, 32'd4, 5'd0);
        wait_done("len0", 1);

        // Address wrap.
        bd_write(8'hFC, 32'hFEED_00FC);
        bd_write(8'h00, 32'h0000_BEEF);
        exp_acc.push_back(m_acc(1'b0, 32'hFFFF_FFFC, 32'h0));
        exp_acc.push_back(m_acc(1'b0, 32'h0000_0000, 32'h0));
        exp_rd.push_back(32'hFEED_00FC);
        exp_rd.push_back(32'h0000_BEEF);
        start_burst(1'b0, 32'hFFFF_FFFC, 32'd4, 5'd2);
        wait_done("wrap", 3);
        tick();

        // Reset during word 2 of a 4-word load, then a fresh burst.
        for (int unsigned k = 0; k < 4; k++) bd_write(8'(32'h40 + 4 * k), 32'hA5A5_0040 + 32'(4 * k));
        exp_acc.push_back(m_acc(1'b0, 32'h40, 32'h0));
        start_burst(1'b0, 32'h40, 32'd4, 5'd4);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy",   96'(bus.m_busy),   96'(0));
        check("arst_rvalid", 96'(bus.m_rvalid), 96'(0));
        check("arst_done",   96'(bus.m_done),   96'(0));
        check("arst_rdata",  96'(bus.m_rdata),  96'(0));
        check("arst_en",     96'({bus.r_en_mem, bus.w_en_mem}), 96'(0));
        check("arst_addr",   96'(bus.data_addr), 96'(0));
        tick();
        tick();
        rst = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_no_done", 96'(bus.m_done), 96'(0));
        end
        check("arst_left", 96'(exp_acc.size() + exp_rd.size()), 96'(0));
        tick();
        for (int unsigned k = 0; k < 2; k++) begin
            exp_acc.push_back(m_acc(1'b0, 32'h40 + 32'(4 * k), 32'h0));
            exp_rd.push_back(32'hA5A5_0040 + 32'(4 * k));
        end
        start_burst(1'b0, 32'h40, 32'd4, 5'd2);
        wait_done("restart", 3);
        tick();
        check("final_left", 96'(exp_acc.size() + exp_rd.size() + exp_srd.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
